mem_wb_stage_buf: RTL

- Parametrised MEM→WB pipeline stage for the processor, carrying the control and data fields from the memory stage to write-back.
- Adds a valid/ready handshake, a 2-entry skid buffer, flush and bubble handling on top of a plain stage register.
- Lets write-back or a register-file port stall the pipeline without a combinational ready path back into MEM.
- Sits between the data-memory stage and the write-back mux / register file.

---
 rtl/mem_wb_stage_buf.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage_buf.sv
// mem_wb_stage_buf
//   MEM -> WB pipeline stage register with a valid/ready handshake and a
//   two-entry skid buffer (main + skid). readyM comes straight from the skid
//   valid flop, so a write-back stall never forms a combinational path back
//   into the memory stage. All state updates happen on the falling clock
//   edge, in step with the other stage registers.
//
//   Optional build macro: MEM_WB_STALL_CNT_EN
//     defined   -> adds stallCntW, a saturating count of stalled cycles
//                  (validW && !readyW), cleared by reset and flush.
//     undefined -> no counter and no stallCntW port.
//
// Ports
//   clk        stage clock (negedge active)
//   rst_n      asynchronous active-low reset
//   flush      synchronous squash of all held entries
//   validM     MEM presents an entry
//   readyM     stage can accept an entry this cycle
//   regWriteM, memToRegM, writeRegM, readDataM, ALUOutM   fields from MEM
//   validW     WB entry valid
//   readyW     WB consumes the entry
//   regWriteW  register-write enable, masked by validW
//   memToRegW, writeRegW, readDataW, ALUOutW             held fields to WB
//   stallCntW  stall counter (MEM_WB_STALL_CNT_EN only)

module mem_wb_stage_buf #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  validM,
  output logic                  readyM,
  input  logic                  regWriteM,
  input  logic                  memToRegM,
  input  logic [REG_ADDR_W-1:0] writeRegM,
  input  logic [DATA_W-1:0]     readDataM,
  input  logic [DATA_W-1:0]     ALUOutM,
  output logic                  validW,
  input  logic                  readyW,
  output logic                  regWriteW,
  output logic                  memToRegW,
  output logic [REG_ADDR_W-1:0] writeRegW,
  output logic [DATA_W-1:0]     readDataW,
  output logic [DATA_W-1:0]     ALUOutW
`ifdef MEM_WB_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]      stallCntW
`endif
);

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0]     read_data;
    logic [DATA_W-1:0]     alu_out;
  } entry_t;

  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;

  entry_t in_entry;
  logic   transfer_in;
  logic   transfer_out;
  logic   main_free;

  always_comb begin
    in_entry            = '0;
    in_entry.reg_write  = regWriteM;
    in_entry.mem_to_reg = memToRegM;
    in_entry.write_reg  = writeRegM;
    in_entry.read_data  = readDataM;
    in_entry.alu_out    = ALUOutM;
  end

  assign readyM       = !skid_valid;
  assign transfer_in  = validM && !skid_valid;
  assign transfer_out = main_valid && readyW;
  // Main can take a new entry when it is empty or its entry leaves this edge.
  assign main_free    = !main_valid || transfer_out;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      // Data fields are deliberately left alone; only the valids drop.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // Oldest entry first: the skid entry is never bypassed by the input.
        main_q     <= skid_q;
        main_valid <= 1'b1;
        // readyM is low whenever skid is occupied, so transfer_in cannot be
        // set here today; the branch keeps ordering correct if that changes.
        if (transfer_in) begin
          skid_q     <= in_entry;
          skid_valid <= 1'b1;
        end else begin
          skid_valid <= 1'b0;
        end
      end else if (transfer_in) begin
        main_q     <= in_entry;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (transfer_in) begin
      skid_q     <= in_entry;
      skid_valid <= 1'b1;
    end
  end

  assign validW    = main_valid;
  assign regWriteW = main_q.reg_write & main_valid;
  assign memToRegW = main_q.mem_to_reg;
  assign writeRegW = main_q.write_reg;
  assign readDataW = main_q.read_data;
  assign ALUOutW   = main_q.alu_out;

`ifdef MEM_WB_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (main_valid && !readyW && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign stallCntW = stall_cnt;
`endif

endmodule
